// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares the single data-memory port between the pipeline memory stage (M)
//   and a secondary requester (D: debug/DMA). M normally wins. D is guaranteed
//   a grant after waiting STARVE_LIMIT consecutive cycles. That grant is taken
//   by stalling the pipeline for one cycle.
//
// Parameters
//   DATA_WIDTH    data width of both requesters and the memory
//   MEM_ADDR_W    memory word-address width
//   STARVE_LIMIT  max consecutive cycles D may wait while M holds the port (>=1)
//
// Ports
//   i_clk, i_arst              clock, synchronous active-high reset
//   i_m_req/we/addr/wdata      memory-stage request
//   o_m_rdata                  M load data (combinational from i_mem_rdata)
//   o_m_stall                  hold memory stage and earlier stages
//   i_d_valid/we/addr/wdata    D request. D holds it stable while not ready.
//   o_d_ready                  D request accepted this cycle
//   o_d_rvalid, o_d_rdata      D read response, one cycle after acceptance
//   o_mem_we/addr/wdata        to memory
//   i_mem_rdata                from memory (combinational read)
//   o_stall_cnt, o_d_xfer_cnt  wrapping performance counters. They exist only
//                              when DMEM_ARB_PERF_EN is defined.
module dmem_port_arbiter #(
  parameter int DATA_WIDTH   = 64,
  parameter int MEM_ADDR_W   = 10,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic                  i_m_req,
  input  logic                  i_m_we,
  input  logic [MEM_ADDR_W-1:0] i_m_addr,
  input  logic [DATA_WIDTH-1:0] i_m_wdata,
  output logic [DATA_WIDTH-1:0] o_m_rdata,
  output logic                  o_m_stall,
  input  logic                  i_d_valid,
  input  logic                  i_d_we,
  input  logic [MEM_ADDR_W-1:0] i_d_addr,
  input  logic [DATA_WIDTH-1:0] i_d_wdata,
  output logic                  o_d_ready,
  output logic                  o_d_rvalid,
  output logic [DATA_WIDTH-1:0] o_d_rdata,
  output logic                  o_mem_we,
  output logic [MEM_ADDR_W-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]           o_stall_cnt,
  output logic [31:0]           o_d_xfer_cnt
`endif
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_FORCE = CNT_W'(STARVE_LIMIT - 1);

  typedef enum logic {
    PRIO_M,
    FORCE_D
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      starve_q, starve_d;
  logic                  d_grant;
  logic                  m_stall;
  logic                  d_xfer;
  logic                  d_rvalid_q, d_rvalid_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;

  // Arbitration FSM. FORCE_D lasts exactly one cycle. If D withdrew its
  // request by then, M simply keeps the port and is not stalled.
  always_comb begin
    state_d = PRIO_M;
    d_grant = 1'b0;
    m_stall = 1'b0;
    unique case (state_q)
      PRIO_M: begin
        d_grant = !i_m_req && i_d_valid;
        if (i_d_valid && !d_grant && (starve_q == CNT_FORCE)) begin
          state_d = FORCE_D;
        end
      end
      FORCE_D: begin
        d_grant = i_d_valid;
        m_stall = i_m_req && i_d_valid;
      end
      default: ;
    endcase
  end

  assign d_xfer = i_d_valid && d_grant;

  // The wait counter saturates so that it never wraps back below the force threshold.
  always_comb begin
    starve_d = starve_q;
    if (!i_d_valid || d_xfer) begin
      starve_d = '0;
    end else if (starve_q != CNT_MAX) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_comb begin
    d_rvalid_d = d_xfer && !i_d_we;
    d_rdata_d  = d_rvalid_d ? i_mem_rdata : d_rdata_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      state_q    <= PRIO_M;
      starve_q   <= '0;
      d_rvalid_q <= 1'b0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      d_rvalid_q <= d_rvalid_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  // A stalled M store must not reach memory. The pipeline re-presents it on the next cycle.
  assign o_mem_we    = d_grant ? i_d_we    : (i_m_req && i_m_we && !m_stall);
  assign o_mem_addr  = d_grant ? i_d_addr  : i_m_addr;
  assign o_mem_wdata = d_grant ? i_d_wdata : i_m_wdata;

  assign o_m_rdata  = i_mem_rdata;
  assign o_m_stall  = m_stall;
  assign o_d_ready  = d_grant;
  assign o_d_rvalid = d_rvalid_q;
  assign o_d_rdata  = d_rdata_q;

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] xfer_cnt_q, xfer_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, m_stall};
    xfer_cnt_d  = xfer_cnt_q + {31'd0, d_xfer};
  end

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      stall_cnt_q <= '0;
      xfer_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      xfer_cnt_q  <= xfer_cnt_d;
    end
  end

  assign o_stall_cnt  = stall_cnt_q;
  assign o_d_xfer_cnt = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;
  localparam int DW = 64;
  localparam int AW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          arst, m_req, m_we, d_valid, d_we;
  logic [AW-1:0] m_addr, d_addr, mem_addr;
  logic [DW-1:0] m_wdata, d_wdata, m_rdata, d_rdata, mem_wdata, mem_rdata;
  logic          m_stall, d_ready, d_rvalid, mem_we;

  logic          l1_stall, l1_ready, l1_rvalid, l1_mem_we;
  logic [AW-1:0] l1_mem_addr;
  logic [DW-1:0] l1_m_rdata, l1_d_rdata, l1_mem_wdata;
  logic [DW-1:0] l1_mem_rdata;
  assign l1_mem_rdata = '0;

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] stall_cnt, xfer_cnt, l1_stall_cnt, l1_xfer_cnt;
`endif

  dmem_port_arbiter #(.DATA_WIDTH(DW), .MEM_ADDR_W(AW), .STARVE_LIMIT(8)) dut (
    .i_clk(clk), .i_arst(arst),
    .i_m_req(m_req), .i_m_we(m_we), .i_m_addr(m_addr), .i_m_wdata(m_wdata),
    .o_m_rdata(m_rdata), .o_m_stall(m_stall),
    .i_d_valid(d_valid), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .o_d_ready(d_ready), .o_d_rvalid(d_rvalid), .o_d_rdata(d_rdata),
    .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata)
`ifdef DMEM_ARB_PERF_EN
    , .o_stall_cnt(stall_cnt), .o_d_xfer_cnt(xfer_cnt)
`endif
  );

  // STARVE_LIMIT=1 instance sharing the same requests: M and D must alternate.
  dmem_port_arbiter #(.DATA_WIDTH(DW), .MEM_ADDR_W(AW), .STARVE_LIMIT(1)) dut_l1 (
    .i_clk(clk), .i_arst(arst),
    .i_m_req(m_req), .i_m_we(m_we), .i_m_addr(m_addr), .i_m_wdata(m_wdata),
    .o_m_rdata(l1_m_rdata), .o_m_stall(l1_stall),
    .i_d_valid(d_valid), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .o_d_ready(l1_ready), .o_d_rvalid(l1_rvalid), .o_d_rdata(l1_d_rdata),
    .o_mem_we(l1_mem_we), .o_mem_addr(l1_mem_addr), .o_mem_wdata(l1_mem_wdata),
    .i_mem_rdata(l1_mem_rdata)
`ifdef DMEM_ARB_PERF_EN
    , .o_stall_cnt(l1_stall_cnt), .o_d_xfer_cnt(l1_xfer_cnt)
`endif
  );

  // Data memory: combinational read, write on the clock edge.
  logic [DW-1:0] mem [0:1023];
  assign mem_rdata = mem[mem_addr];

  initial begin : memory
    for (int unsigned i = 0; i < 1024; i++) mem[i] = '0;
    mem[10'h010] = 64'hDEAD_BEEF;
    mem[10'h020] = 64'hAAAA;
    mem[10'h030] = 64'h3030;
    mem[10'h040] = 64'h4040;
    forever begin
      @(posedge clk);
      if (mem_we === 1'b1) mem[mem_addr] <= mem_wdata;
    end
  end

  typedef struct {
    string         name;
    logic          d_ready, m_stall, mem_we, d_rvalid;
    bit            ck_drdata;
    logic [DW-1:0] d_rdata_v;
    bit            ck_mrdata;
    logic [DW-1:0] m_rdata_v;
    bit            ck_mem;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_v;
    bit            ck_l1;
    logic          l1_ready, l1_stall;
    bit            ck_perf;
    logic [31:0]   stall_cnt_v, xfer_cnt_v;
  } exp_t;

  exp_t          eq[$];
  logic [DW-1:0] rq[$];
  int            n_chk  = 0;
  int            n_fail = 0;

  task automatic chk(string n, logic [DW-1:0] act, logic [DW-1:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", n, act, expv);
    end
  endtask

  function automatic exp_t mk(string n, logic rdy, logic st, logic we, logic rv);
    exp_t e;
    e.name = n; e.d_ready = rdy; e.m_stall = st; e.mem_we = we; e.d_rvalid = rv;
    e.ck_drdata = 0; e.d_rdata_v = '0;
    e.ck_mrdata = 0; e.m_rdata_v = '0;
    e.ck_mem = 0; e.mem_a = '0; e.mem_v = '0;
    e.ck_l1 = 0; e.l1_ready = 0; e.l1_stall = 0;
    e.ck_perf = 0; e.stall_cnt_v = '0; e.xfer_cnt_v = '0;
    return e;
  endfunction

  // Monitor: pops one expectation per presented cycle and one read response per rvalid pulse.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (d_rvalid === 1'b1) begin
        if (rq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL d_rvalid_unexpected: got rvalid=1 required no response");
        end else begin
          chk("d_rdata_resp", d_rdata, rq.pop_front());
        end
      end
      if (eq.size() != 0) begin
        e = eq.pop_front();
        chk({e.name, ".d_ready"},  d_ready,  e.d_ready);
        chk({e.name, ".m_stall"},  m_stall,  e.m_stall);
        chk({e.name, ".mem_we"},   mem_we,   e.mem_we);
        chk({e.name, ".d_rvalid"}, d_rvalid, e.d_rvalid);
        if (e.ck_drdata) chk({e.name, ".d_rdata"}, d_rdata, e.d_rdata_v);
        if (e.ck_mrdata) chk({e.name, ".m_rdata"}, m_rdata, e.m_rdata_v);
        if (e.ck_mem)    chk({e.name, ".mem"}, mem[e.mem_a], e.mem_v);
        if (e.ck_l1) begin
          chk({e.name, ".l1_ready"}, l1_ready, e.l1_ready);
          chk({e.name, ".l1_stall"}, l1_stall, e.l1_stall);
        end
`ifdef DMEM_ARB_PERF_EN
        if (e.ck_perf) begin
          chk({e.name, ".stall_cnt"}, 64'(stall_cnt), 64'(e.stall_cnt_v));
          chk({e.name, ".xfer_cnt"},  64'(xfer_cnt),  64'(e.xfer_cnt_v));
        end
`endif
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    arst = 0; m_req = 0; m_we = 0; m_addr = '0; m_wdata = '0;
    d_valid = 0; d_we = 0; d_addr = '0; d_wdata = '0;
  endtask

  // M loads continuously, D read waits: forced grant on cycle 8, D drops valid on cycle 9.
  task automatic scen3(string tag);
    exp_t e;
    for (int c = 0; c < 10; c++) begin
      tick();
      idle();
      m_req = 1; m_addr = 10'h040;
      d_valid = (c < 9); d_addr = 10'h010;
      e = mk($sformatf("%s_c%0d", tag, c), c == 8, c == 8, 1'b0, c == 9);
      e.ck_l1 = 1;
      e.l1_ready = (c < 9) && ((c % 2) == 1);
      e.l1_stall = (c < 9) && ((c % 2) == 1);
      if (c == 0 || c == 9) begin e.ck_mrdata = 1; e.m_rdata_v = 64'h4040; end
      eq.push_back(e);
      if (c == 8) rq.push_back(64'hDEAD_BEEF);
    end
  endtask

  initial begin : stimulus
    exp_t e;
    idle();
    arst = 1;
    tick();
    arst = 1;
    e = mk("reset", 0, 0, 0, 0);
    e.ck_drdata = 1; e.d_rdata_v = '0; e.ck_l1 = 1;
    e.ck_perf = 1;
    eq.push_back(e);

    // D only read.
    tick(); idle(); d_valid = 1; d_addr = 10'h010;
    eq.push_back(mk("d_only_acc", 1, 0, 0, 0));
    rq.push_back(64'hDEAD_BEEF);
    tick(); idle();
    eq.push_back(mk("d_only_rsp", 0, 0, 0, 1));

    // Reset on the cycle of a D read transfer: the response is dropped.
    tick(); idle(); d_valid = 1; d_addr = 10'h010; arst = 1;
    e = mk("rst_xfer", 1, 0, 0, 0);
    e.ck_drdata = 1; e.d_rdata_v = 64'hDEAD_BEEF;
    eq.push_back(e);
    tick(); idle();
    e = mk("rst_mid_read", 0, 0, 0, 0);
    e.ck_drdata = 1; e.d_rdata_v = '0;
    eq.push_back(e);

    // D waits 7 cycles, then reset on the cycle that would enter FORCE_D.
    for (int c = 0; c < 8; c++) begin
      tick(); idle();
      m_req = 1; m_addr = 10'h040; d_valid = 1; d_addr = 10'h010;
      arst = (c == 7);
      eq.push_back(mk($sformatf("prewait_c%0d", c), 0, 0, 0, 0));
    end
    scen3("starve");

    // Stolen cycle with an M store: the store must wait for the retry.
    for (int c = 0; c < 11; c++) begin
      tick(); idle();
      if (c < 8) begin
        m_req = 1; m_addr = 10'h040;
      end else if (c < 10) begin
        m_req = 1; m_we = 1; m_addr = 10'h020; m_wdata = 64'h55;
      end
      d_valid = (c < 9); d_addr = 10'h010;
      e = mk($sformatf("mstore_c%0d", c), c == 8, c == 8, c == 9, c == 9);
      if (c >= 8) begin
        e.ck_mem = 1; e.mem_a = 10'h020;
        e.mem_v = (c == 10) ? 64'h55 : 64'hAAAA;
      end
      eq.push_back(e);
      if (c == 8) rq.push_back(64'hDEAD_BEEF);
    end

    // D write on a stolen cycle to the address M is loading.
    for (int c = 0; c < 11; c++) begin
      tick(); idle();
      if (c < 10) begin
        m_req = 1; m_addr = (c < 8) ? 10'h040 : 10'h030;
      end
      d_valid = (c < 9); d_we = 1; d_addr = 10'h030; d_wdata = 64'h1234;
      e = mk($sformatf("dwrite_c%0d", c), c == 8, c == 8, c == 8, 0);
      if (c == 9) begin e.ck_mrdata = 1; e.m_rdata_v = 64'h1234; end
      eq.push_back(e);
    end

    // Counters: reset, then the starvation scenario twice.
    tick(); idle(); arst = 1;
    eq.push_back(mk("perf_rst", 0, 0, 0, 0));
    tick(); idle();
    e = mk("perf_zero", 0, 0, 0, 0);
    e.ck_perf = 1;
    eq.push_back(e);
    scen3("perf1");
    scen3("perf2");
    tick(); idle();
    e = mk("perf_end", 0, 0, 0, 0);
    e.ck_perf = 1; e.stall_cnt_v = 32'd2; e.xfer_cnt_v = 32'd2;
    eq.push_back(e);

    tick(); idle();
    repeat (3) @(negedge clk);
    chk("exp_queue_drained", 64'(eq.size()), 64'd0);
    chk("rsp_queue_drained", 64'(rq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
